// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

   // Iteration counter width for a given operand width (never below one bit).
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/ripple_adder_w.sv
// WIDTH-bit ripple-carry adder: half adder on bit 0, full-adder chain above,
// carry-out exported for the multiplier's shift MSB.
module ripple_adder_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:1] carry_s;

   assign sum[0]     = x[0] ^ y[0];
   assign carry_s[1] = x[0] & y[0];

   for (genvar i = 1; i < WIDTH; i++) begin : g_fa
      assign sum[i]       = x[i] ^ y[i] ^ carry_s[i];
      assign carry_s[i+1] = (x[i] & y[i]) | (x[i] & carry_s[i]) | (y[i] & carry_s[i]);
   end

   assign cout = carry_s[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential radix-2 unsigned multiplier: one conditional add and right shift per
// clock through a ripple adder, with a start/busy/done handshake.
module seq_shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mq_q, mq_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     addend_s;
   logic [WIDTH-1:0]     sum_s;
   logic                 cout_s;
   logic [2*WIDTH-1:0]   shift_s;

   assign addend_s = mq_q[0] ? mcand_q : {WIDTH{1'b0}};

   ripple_adder_w #(.WIDTH(WIDTH)) u_adder (
      .x    (acc_q),
      .y    (addend_s),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // The carry-out becomes the new MSB; mq[0] has been consumed and drops off.
   assign shift_s = {cout_s, sum_s, mq_q[WIDTH-1:1]};

   // State register and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q <= {WIDTH{1'b0}};
         mq_q    <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         p_q     <= {(2*WIDTH){1'b0}};
      end else begin
         mcand_q <= mcand_d;
         mq_q    <= mq_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: load on accept, one add/shift per RUN cycle, product at exit.
   always_comb begin
      mcand_d = mcand_q;
      mq_d    = mq_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = a;
               mq_d    = b;
               acc_d   = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d   = cnt_q;
            end
         end
         RUN: begin
            acc_d = shift_s[2*WIDTH-1:WIDTH];
            mq_d  = shift_s[WIDTH-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               p_d = shift_s;
            end else begin
               p_d = p_q;
            end
         end
         DONE:    cnt_d = cnt_q;
         default: cnt_d = {CW{1'b0}};
      endcase
   end

   // Output decode from the next state so busy/done come straight from flops.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule
